// File: rtl/kmp_stream_matcher.sv
// rtl/kmp_stream_matcher.sv - streaming Knuth-Morris-Pratt pattern matcher
// Builds the failure table from the pattern RAM, then scans a valid/ready text stream.
module kmp_stream_matcher #(
  parameter int CHAR_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int POS_W   = 16,
  parameter int CNT_W   = 8,
  localparam int LW = $clog2(PAT_MAX + 1),
  localparam int AW = $clog2(PAT_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LW-1:0]     pat_len,
  input  logic              pat_we,
  input  logic [AW-1:0]     pat_addr,
  input  logic [CHAR_W-1:0] pat_data,
  input  logic              txt_valid,
  input  logic [CHAR_W-1:0] txt_data,
  input  logic              txt_last,
  output logic              txt_ready,
  output logic              match,
  output logic [POS_W-1:0]  match_pos,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_SEARCH, S_DONE} state_t;

  state_t            state;
  logic [CHAR_W-1:0] pat_mem  [PAT_MAX];
  logic [LW-1:0]     fail_mem [PAT_MAX];
  logic [LW-1:0]     len, i, k, j;
  logic [POS_W-1:0]  txt_idx;

  logic [AW-1:0] i_a, k_a, j_a, km1_a, jm1_a, lm1_a;
  logic [LW-1:0] j_inc;
  logic          b_eq, s_eq, backoff, accept;

  assign i_a   = AW'(i);
  assign k_a   = AW'(k);
  assign j_a   = AW'(j);
  assign km1_a = AW'(k - LW'(1));
  assign jm1_a = AW'(j - LW'(1));
  assign lm1_a = AW'(len - LW'(1));
  assign j_inc = j + LW'(1);

  assign b_eq = (pat_mem[i_a] == pat_mem[k_a]);
  assign s_eq = (txt_data == pat_mem[j_a]);

  // Back-off and match both come from the registered j; a back-off stalls the stream.
  assign backoff   = (state == S_SEARCH) && txt_valid && !s_eq && (j != '0);
  assign txt_ready = (state == S_SEARCH) && !backoff;
  assign accept    = txt_valid && txt_ready;

  assign busy = (state == S_BUILD) || (state == S_SEARCH);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (pat_we && !busy && (int'(pat_addr) < PAT_MAX))
      pat_mem[pat_addr] <= pat_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      len         <= '0;
      i           <= '0;
      k           <= '0;
      j           <= '0;
      txt_idx     <= '0;
      match       <= 1'b0;
      match_pos   <= '0;
      match_count <= '0;
      err         <= 1'b0;
    end else begin
      match <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            match_pos   <= '0;
            match_count <= '0;
            txt_idx     <= '0;
            if ((pat_len != '0) && (int'(pat_len) <= PAT_MAX)) begin
              state       <= S_BUILD;
              len         <= pat_len;
              i           <= LW'(1);
              k           <= '0;
              err         <= 1'b0;
              fail_mem[0] <= '0;
            end else begin
              state <= S_DONE;
              err   <= 1'b1;
            end
          end
        end
        S_BUILD: begin
          if (i == len) begin
            state <= S_SEARCH;
            j     <= '0;
          end else if (b_eq) begin
            fail_mem[i_a] <= k + LW'(1);
            k             <= k + LW'(1);
            i             <= i + LW'(1);
          end else if (k != '0) begin
            k <= fail_mem[km1_a];
          end else begin
            fail_mem[i_a] <= '0;
            i             <= i + LW'(1);
          end
        end
        S_SEARCH: begin
          if (backoff) begin
            j <= fail_mem[jm1_a];
          end else if (accept) begin
            txt_idx <= txt_idx + POS_W'(1);
            if (s_eq) begin
              if (j_inc == len) begin
                // Resume from the longest proper border so overlapping matches are found.
                match     <= 1'b1;
                match_pos <= txt_idx;
                if (match_count != '1)
                  match_count <= match_count + CNT_W'(1);
                j <= fail_mem[lm1_a];
              end else begin
                j <= j_inc;
              end
            end
            if (txt_last)
              state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmp_stream_matcher.sv
// tb/tb_kmp_stream_matcher.sv - scoreboard bench for kmp_stream_matcher
// Expected matches come from a brute-force window compare of pattern against text.
module tb_kmp_stream_matcher;

  localparam int CW = 8;
  localparam int PM = 8;
  localparam int PW = 16;
  localparam int NW = 2;
  localparam int LW = $clog2(PM + 1);
  localparam int AW = $clog2(PM);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] pat_len;
  logic          pat_we;
  logic [AW-1:0] pat_addr;
  logic [CW-1:0] pat_data;
  logic          txt_valid;
  logic [CW-1:0] txt_data;
  logic          txt_last;
  logic          txt_ready;
  logic          match;
  logic [PW-1:0] match_pos;
  logic [NW-1:0] match_count;
  logic          busy, done, err;

  kmp_stream_matcher #(.CHAR_W(CW), .PAT_MAX(PM), .POS_W(PW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .pat_len(pat_len),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
    .txt_valid(txt_valid), .txt_data(txt_data), .txt_last(txt_last),
    .txt_ready(txt_ready), .match(match), .match_pos(match_pos),
    .match_count(match_count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int pos; int cnt;} exp_t;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_final;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every match pulse must correspond to the oldest predicted match.
  always @(negedge clk) begin
    if (match) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_match: got pos %0d, expected no match", match_pos);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("match_pos", int'(match_pos), e.pos);
        chk("match_count_at_match", int'(match_count), e.cnt);
      end
    end
  end

  task automatic write_pat(input logic [CW-1:0] p[$]);
    foreach (p[m]) begin
      @(posedge clk); #1;
      pat_we = 1'b1; pat_addr = AW'(m); pat_data = p[m];
    end
    @(posedge clk); #1;
    pat_we = 1'b0;
  endtask

  task automatic model(input logic [CW-1:0] p[$], input logic [CW-1:0] t[$]);
    int cnt;
    bit hit;
    exp_t e;
    cnt = 0;
    for (int q = p.size() - 1; q < t.size(); q++) begin
      hit = 1'b1;
      for (int m = 0; m < p.size(); m++)
        if (t[q - p.size() + 1 + m] != p[m]) hit = 1'b0;
      if (hit) begin
        cnt = (cnt < (1 << NW) - 1) ? cnt + 1 : cnt;
        e.pos = q; e.cnt = cnt;
        exp_q.push_back(e);
      end
    end
    exp_final = cnt;
  endtask

  task automatic run(input logic [CW-1:0] p[$], input logic [CW-1:0] t[$],
                     input bit with_last, output int stalls);
    bit acc;
    int budget;
    stalls = 0;
    write_pat(p);
    model(p, t);
    @(posedge clk); #1;
    pat_len = LW'(p.size()); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Write attempt while busy must not disturb the running pattern.
    pat_we = 1'b1; pat_addr = '0; pat_data = 8'hFF;
    @(posedge clk); #1;
    pat_we = 1'b0;
    foreach (t[x]) begin
      while ($urandom_range(3) == 0) begin
        txt_valid = 1'b0;
        @(posedge clk); #1;
      end
      txt_valid = 1'b1; txt_data = t[x];
      txt_last = with_last && (x == t.size() - 1);
      acc = 1'b0; budget = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        if (txt_ready) acc = 1'b1;
        else if (x > 0) stalls++;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) begin
        chk("txt_accept_timeout", 0, 1);
        break;
      end
    end
    txt_valid = 1'b0; txt_last = 1'b0;
    if (with_last) begin
      budget = 0;
      @(negedge clk);
      while (!done && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      chk("done_after_last", int'(done), 1);
      @(negedge clk);
      chk("pending_matches", exp_q.size(), 0);
      chk("final_count", int'(match_count), exp_final);
      chk("err_ok_run", int'(err), 0);
      chk("busy_in_done", int'(busy), 0);
      chk("ready_in_done", int'(txt_ready), 0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, int'(txt_ready), 0);
    chk({tag, "_match"}, int'(match), 0);
    chk({tag, "_pos"}, int'(match_pos), 0);
    chk({tag, "_count"}, int'(match_count), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic bad_len(input int l);
    @(posedge clk); #1;
    pat_len = LW'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; txt_valid = 1'b1; txt_data = 8'h41;
    repeat (3) begin
      @(negedge clk);
      chk("badlen_done", int'(done), 1);
      chk("badlen_err", int'(err), 1);
      chk("badlen_ready", int'(txt_ready), 0);
      chk("badlen_count", int'(match_count), 0);
    end
    @(posedge clk); #1;
    txt_valid = 1'b0;
  endtask

  function automatic void str2q(input string s, output logic [CW-1:0] q[$]);
    q = {};
    for (int c = 0; c < s.len(); c++) q.push_back(s[c]);
  endfunction

  initial begin
    logic [CW-1:0] p[$];
    logic [CW-1:0] t[$];
    int st;
    rst = 1'b1; start = 1'b0; pat_len = '0; pat_we = 1'b0; pat_addr = '0;
    pat_data = '0; txt_valid = 1'b0; txt_data = '0; txt_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    str2q("ABAB", p); str2q("ABABAB", t);
    run(p, t, 1'b1, st);
    chk("abab_count", int'(match_count), 2);

    str2q("AAAA", p); str2q("AAAAAA", t);
    run(p, t, 1'b1, st);
    chk("aaaa_count", int'(match_count), 3);

    str2q("ABAC", p); str2q("ABABAC", t);
    run(p, t, 1'b1, st);
    chk("abac_backoffs", st, 1);
    chk("abac_pos", int'(match_pos), 5);

    str2q("A", p); str2q("AAAAA", t);
    run(p, t, 1'b1, st);
    chk("sat_count", int'(match_count), 3);

    bad_len(0);
    bad_len(PM + 1);

    str2q("ABAB", p); str2q("ABAB", t);
    run(p, t, 1'b0, st);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    chk("midrst_queue", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("midrst_no_match", int'(match), 0);

    str2q("BAB", p); str2q("ABABABB", t);
    run(p, t, 1'b1, st);
    chk("after_rst_count", int'(match_count), 2);

    for (int r = 0; r < 25; r++) begin
      int pl, tl;
      pl = $urandom_range(PM, 1);
      tl = $urandom_range(30, 1);
      p = {}; t = {};
      for (int m = 0; m < pl; m++) p.push_back(8'h41 + CW'($urandom_range(1)));
      for (int m = 0; m < tl; m++) t.push_back(8'h41 + CW'($urandom_range(1)));
      run(p, t, 1'b1, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
